// File: rtl/vip_gray_expand_core_if.sv
// Stream, control-packet and status bundle for vip_gray_expand_core.
// slave = core side, master = wrapper side.
interface vip_gray_expand_core_if #(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_OUT     = 3
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_OUT;

  logic [1:0]                 mode;
  logic [BITS_PER_SYMBOL-1:0] threshold;
  logic                       stall_in;
  logic                       read;
  logic [BITS_PER_SYMBOL-1:0] data_in;
  logic                       end_of_video;
  logic [15:0]                width_in;
  logic [15:0]                height_in;
  logic [3:0]                 interlaced_in;
  logic                       vip_ctrl_valid;
  logic                       stall_out;
  logic                       write;
  logic [DW-1:0]              data_out;
  logic                       end_of_video_out;
  logic [15:0]                width_out;
  logic [15:0]                height_out;
  logic [3:0]                 interlaced_out;
  logic                       vip_ctrl_busy;
  logic                       vip_ctrl_send;
  logic                       frame_err;

  modport slave (
    input  mode, threshold, stall_in, data_in,
    input  end_of_video, width_in, height_in,
    input  interlaced_in, vip_ctrl_valid,
    input  stall_out, vip_ctrl_busy,
    output read, write, data_out, end_of_video_out,
    output width_out, height_out, interlaced_out,
    output vip_ctrl_send, frame_err
  );

  modport master (
    output mode, threshold, stall_in, data_in,
    output end_of_video, width_in, height_in,
    output interlaced_in, vip_ctrl_valid,
    output stall_out, vip_ctrl_busy,
    input  read, write, data_out, end_of_video_out,
    input  width_out, height_out, interlaced_out,
    input  vip_ctrl_send, frame_err
  );
endinterface

// File: rtl/vip_gray_expand_core.sv
// Gray-to-multi-symbol expander: pipeline + credit-counted output FIFO.
// Optional macro FRAME_CHECK_EN adds a sticky beat-count check (frame_err).
module vip_gray_expand_core #(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_OUT     = 3,
  parameter int PIPE_DEPTH      = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter logic [BITS_PER_SYMBOL*SYMBOLS_OUT-1:0]
                OVERLAY_COLOR   = 24'hFF0000
) (
  input logic clk,
  input logic rst,
  vip_gray_expand_core_if.slave bus
);
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_OUT;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] M_GRAY    = 2'd0;
  localparam logic [1:0] M_THRESH  = 2'd1;
  localparam logic [1:0] M_INVERT  = 2'd2;
  localparam logic [1:0] M_OVERLAY = 2'd3;

  logic                       r_load;
  logic [1:0]                 r_mode;
  logic [BITS_PER_SYMBOL-1:0] r_thr;
  logic [1:0]                 w_mode;
  logic [BITS_PER_SYMBOL-1:0] w_thr;
  logic [DW-1:0]              w_gray;
  logic                       w_hit;
  logic [DW-1:0]              w_pix;

  logic [PIPE_DEPTH-1:0]      r_pv;
  logic [PIPE_DEPTH-1:0]      r_pe;
  logic [DW-1:0]              r_pd [PIPE_DEPTH];

  logic [DW:0]                r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wptr;
  logic [AW-1:0]              r_rptr;
  logic [CW-1:0]              r_count;
  logic [CW-1:0]              r_infl;
  logic [DW:0]                r_hold;
  logic [DW:0]                w_head;
  logic [CW:0]                w_credit;

  logic                       w_read;
  logic                       w_acc;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_empty;

  logic [15:0]                r_width;
  logic [15:0]                r_height;
  logic [3:0]                 r_il;
  logic                       r_send;

  assign w_credit = {1'b0, r_count} + {1'b0, r_infl};
  assign w_read   = rst & (w_credit < (CW+1)'(FIFO_DEPTH));
  assign w_acc    = w_read & ~bus.stall_in;
  assign w_push   = r_pv[PIPE_DEPTH-1];
  assign w_empty  = (r_count == '0);
  assign w_pop    = ~w_empty & ~bus.stall_out;

  // The load cycle uses the incoming settings directly so the first
  // beat of a new frame already sees them.
  assign w_mode = r_load ? bus.mode      : r_mode;
  assign w_thr  = r_load ? bus.threshold : r_thr;

  // Active mode/threshold: loaded after reset and after each frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load <= 1'b1;
      r_mode <= M_GRAY;
      r_thr  <= '0;
    end else begin
      r_load <= w_acc & bus.end_of_video;
      if (r_load) begin
        r_mode <= bus.mode;
        r_thr  <= bus.threshold;
      end
    end
  end

  // Stage 0 pixel function
  always_comb begin
    w_gray = {SYMBOLS_OUT{bus.data_in}};
    w_hit  = (bus.data_in >= w_thr);
    w_pix  = w_gray;
    unique case (1'b1)
      (w_mode == M_THRESH):  w_pix = w_hit ? '1 : '0;
      (w_mode == M_INVERT):  w_pix = {SYMBOLS_OUT{~bus.data_in}};
      (w_mode == M_OVERLAY): w_pix = w_hit ? OVERLAY_COLOR : w_gray;
      default:               w_pix = w_gray;
    endcase
  end

  // Free-running pipeline; bubbles enter when nothing is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pv <= '0;
      r_pe <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) r_pd[k] <= '0;
    end else begin
      r_pv[0] <= w_acc;
      r_pe[0] <= w_acc & bus.end_of_video;
      r_pd[0] <= w_pix;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pe[k] <= r_pe[k-1];
        r_pd[k] <= r_pd[k-1];
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_pe[PIPE_DEPTH-1], r_pd[PIPE_DEPTH-1]};
    end
  end

  // FIFO pointers, occupancy, in-flight credit and held output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_infl  <= '0;
      r_hold  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_hold <= r_mem[r_rptr];
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_infl  <= r_infl + CW'(w_acc) - CW'(w_push);
    end
  end

  assign w_head = w_empty ? r_hold : r_mem[r_rptr];

  // Control-packet fields and send request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_width  <= 16'd640;
      r_height <= 16'd480;
      r_il     <= 4'd0;
      r_send   <= 1'b0;
    end else begin
      if (bus.vip_ctrl_valid) begin
        r_width  <= bus.width_in;
        r_height <= bus.height_in;
        r_il     <= bus.interlaced_in;
      end
      r_send <= bus.vip_ctrl_valid & ~bus.vip_ctrl_busy;
    end
  end

`ifdef FRAME_CHECK_EN
  logic [31:0] r_beats;
  logic        r_err;
  logic [31:0] w_area;

  assign w_area = {16'd0, r_width} * {16'd0, r_height};

  // Beat counter compared with width*height at frame end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beats <= '0;
      r_err   <= 1'b0;
    end else if (w_acc) begin
      if (bus.end_of_video) begin
        if ((r_beats + 32'd1) != w_area) r_err <= 1'b1;
        r_beats <= '0;
      end else begin
        r_beats <= r_beats + 32'd1;
      end
    end
  end

  assign bus.frame_err = r_err;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.read             = w_read;
  assign bus.write            = ~w_empty;
  assign bus.data_out         = w_head[DW-1:0];
  assign bus.end_of_video_out = w_head[DW];
  assign bus.width_out        = r_width;
  assign bus.height_out       = r_height;
  assign bus.interlaced_out   = r_il;
  assign bus.vip_ctrl_send    = r_send;

endmodule

// File: tb/tb_vip_gray_expand_core.sv
// Directed bench for vip_gray_expand_core with a beat scoreboard.
// Build with FRAME_CHECK_EN to also exercise frame_err.
module tb_vip_gray_expand_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [24:0] q [$];
  logic        m_load = 1'b1;
  logic [1:0]  m_mode = 2'd0;
  logic [7:0]  m_thr  = 8'd0;

  vip_gray_expand_core_if #(.BITS_PER_SYMBOL(8), .SYMBOLS_OUT(3)) bus ();

  vip_gray_expand_core #(
    .BITS_PER_SYMBOL(8),
    .SYMBOLS_OUT(3),
    .PIPE_DEPTH(4),
    .FIFO_DEPTH(8),
    .OVERLAY_COLOR(24'hFF0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic [7:0] p,
                                        input logic [1:0] m,
                                        input logic [7:0] t);
    logic [23:0] g;
    g = {p, p, p};
    case (m)
      2'd1:    return (p >= t) ? 24'hFFFFFF : 24'h000000;
      2'd2:    return {~p, ~p, ~p};
      2'd3:    return (p >= t) ? 24'hFF0000 : g;
      default: return g;
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on each delivered beat
  always @(negedge clk) begin
    logic acc;
    logic [24:0] e;
    if (!rst) begin
      m_load = 1'b1;
      m_mode = 2'd0;
      m_thr  = 8'd0;
      q.delete();
    end else begin
      if (m_load) begin
        m_mode = bus.mode;
        m_thr  = bus.threshold;
      end
      acc = bus.read & ~bus.stall_in;
      if (acc) begin
        q.push_back({bus.end_of_video,
                     model(bus.data_in, m_mode, m_thr)});
      end
      m_load = acc & bus.end_of_video;
      if (bus.write && !bus.stall_out) begin
        if (q.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("beat", {7'd0, bus.end_of_video_out, bus.data_out},
                {7'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input logic e);
    int n;
    n = 0;
    bus.stall_in     = 1'b0;
    bus.data_in      = p;
    bus.end_of_video = e;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.read && n < 200);
    if (n >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.stall_in     = 1'b1;
    bus.end_of_video = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic [15:0] w, input logic [15:0] h,
                      input logic [3:0] il, input logic busy);
    bus.vip_ctrl_valid = 1'b1;
    bus.vip_ctrl_busy  = busy;
    bus.width_in       = w;
    bus.height_in      = h;
    bus.interlaced_in  = il;
    @(posedge clk);
    #1;
    bus.vip_ctrl_valid = 1'b0;
    bus.vip_ctrl_busy  = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_read", bus.read, 32'd0);
    check("rst_write", bus.write, 32'd0);
    check("rst_data", bus.data_out, 32'd0);
    check("rst_eov", bus.end_of_video_out, 32'd0);
    check("rst_width", bus.width_out, 32'd640);
    check("rst_height", bus.height_out, 32'd480);
    check("rst_il", bus.interlaced_out, 32'd0);
    check("rst_send", bus.vip_ctrl_send, 32'd0);
    check("rst_err", bus.frame_err, 32'd0);
  endtask

  initial begin
    int t0;
    int n;
    int acc;
    bus.mode           = 2'd0;
    bus.threshold      = 8'd0;
    bus.stall_in       = 1'b1;
    bus.data_in        = 8'd0;
    bus.end_of_video   = 1'b0;
    bus.width_in       = 16'd0;
    bus.height_in      = 16'd0;
    bus.interlaced_in  = 4'd0;
    bus.vip_ctrl_valid = 1'b0;
    bus.stall_out      = 1'b0;
    bus.vip_ctrl_busy  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("read_after_rel", bus.read, 32'd1);
    @(posedge clk);
    #1;

    // GRAY stream and first-beat latency
    send(8'h10, 1'b0);
    t0 = cyc - 1;
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.write && n < 50);
    check("latency", cyc - t0, 32'd5);
    wait_drain();

    // THRESH then OVERLAY, each loaded at a frame boundary
    bus.mode      = 2'd1;
    bus.threshold = 8'h80;
    send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    bus.mode = 2'd3;
    send(8'h7F, 1'b0);
    send(8'h80, 1'b1);
    wait_drain();

    // INVERT frame with a mode change inside it
    bus.mode = 2'd2;
    wait_drain();
    send(8'h00, 1'b1);
    bus.mode = 2'd2;
    send(8'h01, 1'b0);
    bus.mode = 2'd0;
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    wait_drain();

    // Backpressure: only FIFO plus in-flight beats are taken
    bus.stall_out = 1'b1;
    acc = 0;
    bus.stall_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.data_in = 8'h40 + 8'(i);
      @(negedge clk);
      if (bus.read) acc++;
      @(posedge clk);
      #1;
    end
    bus.stall_in = 1'b1;
    @(negedge clk);
    check("bp_accepts", acc, 32'd8);
    check("bp_read_low", bus.read, 32'd0);
    check("bp_write", bus.write, 32'd1);
    check("bp_head", bus.data_out, {8'd0, q[0][23:0]});
    check("bp_queue", q.size(), 32'd8);
    @(posedge clk);
    #1;
    bus.stall_out = 1'b0;
    wait_drain();
    send(8'h55, 1'b1);
    wait_drain();

    // Control packets, busy and not busy
    ctrl(16'd100, 16'd50, 4'd2, 1'b1);
    @(negedge clk);
    check("ctrl_busy_send", bus.vip_ctrl_send, 32'd0);
    check("ctrl_busy_w", bus.width_out, 32'd100);
    @(posedge clk);
    #1;
    ctrl(16'd320, 16'd240, 4'd3, 1'b0);
    @(negedge clk);
    check("ctrl_send", bus.vip_ctrl_send, 32'd1);
    check("ctrl_w", bus.width_out, 32'd320);
    check("ctrl_h", bus.height_out, 32'd240);
    check("ctrl_il", bus.interlaced_out, 32'd3);
    @(negedge clk);
    check("ctrl_send_pulse", bus.vip_ctrl_send, 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled stream
    bus.stall_out = 1'b1;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    bus.stall_out = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("read_after_rst2", bus.read, 32'd1);
    repeat (8) @(negedge clk);
    check("empty_after_rst", bus.write, 32'd0);
    @(posedge clk);
    #1;
    send(8'h66, 1'b0);
    wait_drain();

`ifdef FRAME_CHECK_EN
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ctrl(16'd4, 16'd2, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) send(8'(i), i == 7);
    @(negedge clk);
    check("frame_ok", bus.frame_err, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) send(8'(i), i == 6);
    @(negedge clk);
    check("frame_short", bus.frame_err, 32'd1);
    @(posedge clk);
    #1;
    wait_drain();
`else
    check("frame_err_tied", bus.frame_err, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
